ram_sdp_clr: RTL



---
 rtl/ram_sdp_clr.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/ram_sdp_clr.sv
// ram_sdp_clr: simple-dual-port synchronous RAM (one write port, one read port, one clock).
// After reset every word is written with CLEAR_VAL, one word per clock; requests are
// accepted only once that sequence completes (ready=1).
// Optional build macro: RAM_OUT_REG_EN adds a second output register stage
// (read latency 2); undefined gives read latency 1.
module ram_sdp_clr #(
  parameter int               DATA_W      = 8,
  parameter int               ADDR_W      = 8,
  parameter int               DEPTH       = 256,
  parameter logic [DATA_W-1:0] CLEAR_VAL  = '0,
  parameter int               WRITE_FIRST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              ready,
  output logic              addr_err
);

  localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0] LP_LAST  = IDX_W'(DEPTH-1);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t            r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_clr_ptr, w_clr_ptr_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_addr_err;

  logic              w_run;
  logic              w_wr_err, w_rd_err;
  logic              w_collide;
  logic [IDX_W-1:0]  w_wr_idx, w_rd_idx;
  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0] w_mem_data;
  logic [DATA_W-1:0] w_rd_word;

  assign w_run     = (r_state == RUN);
  assign w_wr_idx  = wr_addr[IDX_W-1:0];
  assign w_rd_idx  = rd_addr[IDX_W-1:0];
  assign w_wr_err  = wr_en && ({1'b0, wr_addr} >= LP_DEPTH);
  assign w_rd_err  = rd_en && ({1'b0, rd_addr} >= LP_DEPTH);
  // rd in range and addresses equal implies the write is in range too
  assign w_collide = wr_en && rd_en && !w_rd_err && (wr_addr == rd_addr);

  // State register and clear pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // Next state: walk the clear pointer, enter RUN on the edge writing the last word
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      CLEAR: begin
        w_clr_ptr_nxt = r_clr_ptr + IDX_W'(1);
        if (r_clr_ptr == LP_LAST) begin
          w_state_nxt   = RUN;
          w_clr_ptr_nxt = '0;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Single write port shared by the clear sequence and user writes
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_addr = w_wr_idx;
    w_mem_data = wr_data;
    if (!w_run) begin
      w_mem_we   = 1'b1;
      w_mem_addr = r_clr_ptr;
      w_mem_data = CLEAR_VAL;
    end else if (wr_en && !w_wr_err) begin
      w_mem_we = 1'b1;
    end
  end

  // Memory array write
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  // Collision bypass: array read yields old contents, so write-first forwards wr_data
  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    if (w_collide && (WRITE_FIRST != 0)) w_rd_word = wr_data;
  end

  // Stage-1 read register and address-error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_addr_err <= 1'b0;
    end else begin
      r_rd_valid <= w_run && rd_en;
      r_addr_err <= w_run && (w_wr_err || w_rd_err);
      if (w_run && rd_en) r_rd_data <= w_rd_err ? '0 : w_rd_word;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;

  // Stage-2 output register, valid flushed while clearing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_run && r_rd_valid;
      r_out_data  <= r_rd_data;
    end
  end

  assign rd_valid = r_out_valid;
  assign rd_data  = r_out_data;
`else
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
`endif

  assign ready    = w_run;
  assign addr_err = r_addr_err;

endmodule
